// File: rtl/mesi_isc_mem_arbiter_if.sv
// Bundle of the four CPU main-bus request ports plus the arbiter's ack/grant/read-data returns.
// The CPU side (master) holds cmd/addr/data stable until it sees its ack bit.
interface mesi_isc_mem_arbiter_if #(
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
);
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd3_i;
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd2_i;
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd1_i;
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd0_i;
    logic [ADDR_WIDTH-1:0]     mbus_addr3_i;
    logic [ADDR_WIDTH-1:0]     mbus_addr2_i;
    logic [ADDR_WIDTH-1:0]     mbus_addr1_i;
    logic [ADDR_WIDTH-1:0]     mbus_addr0_i;
    logic [DATA_WIDTH-1:0]     mbus_data_wr3_i;
    logic [DATA_WIDTH-1:0]     mbus_data_wr2_i;
    logic [DATA_WIDTH-1:0]     mbus_data_wr1_i;
    logic [DATA_WIDTH-1:0]     mbus_data_wr0_i;
    logic [3:0]                mbus_ack_o;
    logic [DATA_WIDTH-1:0]     mbus_data_rd_o;
    logic [3:0]                grant_o;
    logic                      busy_o;

    modport master (
        output mbus_cmd3_i, mbus_cmd2_i, mbus_cmd1_i, mbus_cmd0_i,
        output mbus_addr3_i, mbus_addr2_i, mbus_addr1_i, mbus_addr0_i,
        output mbus_data_wr3_i, mbus_data_wr2_i, mbus_data_wr1_i, mbus_data_wr0_i,
        input  mbus_ack_o, mbus_data_rd_o, grant_o, busy_o
    );

    modport slave (
        input  mbus_cmd3_i, mbus_cmd2_i, mbus_cmd1_i, mbus_cmd0_i,
        input  mbus_addr3_i, mbus_addr2_i, mbus_addr1_i, mbus_addr0_i,
        input  mbus_data_wr3_i, mbus_data_wr2_i, mbus_data_wr1_i, mbus_data_wr0_i,
        output mbus_ack_o, mbus_data_rd_o, grant_o, busy_o
    );
endinterface

// File: rtl/mesi_isc_mem_arbiter.sv
// Round-robin main-memory controller for four CPUs: grant -> MEM_LAT cycles -> one-cycle ack, MEM_LAT+2 cycles per access.
// Losers are not acked and simply keep their request asserted; ACK always returns through IDLE.
module mesi_isc_mem_arbiter #(
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH_LOG2     = 4,
    parameter int MEM_LAT        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mesi_isc_mem_arbiter_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR = MBUS_CMD_WIDTH'(1);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD = MBUS_CMD_WIDTH'(2);
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic [3:0]                cnt, cnt_nxt;
    logic [1:0]                prio, prio_nxt;
    logic [1:0]                gidx, gidx_nxt;
    logic [3:0]                grant, grant_nxt;
    logic [3:0]                ack, ack_nxt;
    logic [DATA_WIDTH-1:0]     rd_dat, rd_dat_nxt;
    logic                      mem_we;
    logic [DATA_WIDTH-1:0]     mem [DEPTH];

    logic [MBUS_CMD_WIDTH-1:0] cmd_a  [4];
    logic [ADDR_WIDTH-1:0]     addr_a [4];
    logic [DATA_WIDTH-1:0]     wdat_a [4];
    logic [3:0]                req;
    logic                      win_vld;
    logic [1:0]                win_idx;
    logic [MBUS_CMD_WIDTH-1:0] cmd_sel;
    logic [ADDR_WIDTH-1:0]     addr_sel;
    logic [DATA_WIDTH-1:0]     wdat_sel;
    logic [DEPTH_LOG2-1:0]     idx_sel;
    logic                      unused_addr_hi;

    assign cmd_a[0]  = bus.mbus_cmd0_i;
    assign cmd_a[1]  = bus.mbus_cmd1_i;
    assign cmd_a[2]  = bus.mbus_cmd2_i;
    assign cmd_a[3]  = bus.mbus_cmd3_i;
    assign addr_a[0] = bus.mbus_addr0_i;
    assign addr_a[1] = bus.mbus_addr1_i;
    assign addr_a[2] = bus.mbus_addr2_i;
    assign addr_a[3] = bus.mbus_addr3_i;
    assign wdat_a[0] = bus.mbus_data_wr0_i;
    assign wdat_a[1] = bus.mbus_data_wr1_i;
    assign wdat_a[2] = bus.mbus_data_wr2_i;
    assign wdat_a[3] = bus.mbus_data_wr3_i;

    always_comb begin
        req = '0;
        for (int n = 0; n < 4; n++) begin
            req[n] = (cmd_a[n] == CMD_WR) || (cmd_a[n] == CMD_RD);
        end
    end

    // Walk the search order backwards so the requester closest to prio is assigned last and wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 3; k >= 0; k--) begin
            if (req[prio + 2'(k)]) begin
                win_vld = 1'b1;
                win_idx = prio + 2'(k);
            end
        end
    end

    // Address and write data come from the live bus at the access edge, not from a grant-time copy.
    assign cmd_sel        = cmd_a[gidx];
    assign addr_sel       = addr_a[gidx];
    assign wdat_sel       = wdat_a[gidx];
    assign idx_sel        = addr_sel[DEPTH_LOG2-1:0];
    assign unused_addr_hi = ^addr_sel[ADDR_WIDTH-1:DEPTH_LOG2];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        prio_nxt   = prio;
        gidx_nxt   = gidx;
        grant_nxt  = grant;
        ack_nxt    = ack;
        rd_dat_nxt = rd_dat;
        mem_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    grant_nxt = 4'b0001 << win_idx;
                    gidx_nxt  = win_idx;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    ack_nxt   = grant;
                    state_nxt = ST_ACK;
                    if (cmd_sel == CMD_WR) begin
                        mem_we = 1'b1;
                    end else if (cmd_sel == CMD_RD) begin
                        rd_dat_nxt = mem[idx_sel];
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_ACK: begin
                ack_nxt   = '0;
                grant_nxt = '0;
                prio_nxt  = gidx + 2'd1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            prio   <= '0;
            gidx   <= '0;
            grant  <= '0;
            ack    <= '0;
            rd_dat <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            prio   <= prio_nxt;
            gidx   <= gidx_nxt;
            grant  <= grant_nxt;
            ack    <= ack_nxt;
            rd_dat <= rd_dat_nxt;
        end
    end

    // Word array is cleared by reset, so an access interrupted by reset never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[idx_sel] <= wdat_sel;
        end
    end

    assign bus.mbus_ack_o     = ack;
    assign bus.grant_o        = grant;
    assign bus.mbus_data_rd_o = rd_dat;
    assign bus.busy_o         = (state != ST_IDLE);
endmodule

// File: tb/tb_mesi_isc_mem_arbiter.sv
// Bench for mesi_isc_mem_arbiter: directed scenarios plus random traffic, checked by a
// transaction-level round-robin/memory model feeding an expected-ack queue.
module tb_mesi_isc_mem_arbiter;
    localparam int LAT = 2;
    localparam logic [2:0] C_NOP = 3'd0, C_WR = 3'd1, C_RD = 3'd2, C_WRB = 3'd3, C_RDB = 3'd4;

    typedef struct {
        int          cpu;
        int          cyc;
        bit          rd;
        logic [31:0] dat;
    } exp_t;
    typedef struct {
        int cpu;
        int cyc;
    } log_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]  cmd_r  [4];
    logic [31:0] addr_r [4];
    logic [31:0] wdat_r [4];
    logic [2:0]  cmd1_r [4];
    logic [31:0] addr1_r[4];
    logic [31:0] wdat1_r[4];
    logic [3:0]  hold = '0;

    int ntests = 0;
    int nfail  = 0;

    mesi_isc_mem_arbiter_if #(.MBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    mesi_isc_mem_arbiter_if #(.MBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    mesi_isc_mem_arbiter #(.MBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                           .DEPTH_LOG2(4), .MEM_LAT(LAT)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    mesi_isc_mem_arbiter #(.MBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                           .DEPTH_LOG2(4), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    assign bus0.mbus_cmd0_i = cmd_r[0];
    assign bus0.mbus_cmd1_i = cmd_r[1];
    assign bus0.mbus_cmd2_i = cmd_r[2];
    assign bus0.mbus_cmd3_i = cmd_r[3];
    assign bus0.mbus_addr0_i = addr_r[0];
    assign bus0.mbus_addr1_i = addr_r[1];
    assign bus0.mbus_addr2_i = addr_r[2];
    assign bus0.mbus_addr3_i = addr_r[3];
    assign bus0.mbus_data_wr0_i = wdat_r[0];
    assign bus0.mbus_data_wr1_i = wdat_r[1];
    assign bus0.mbus_data_wr2_i = wdat_r[2];
    assign bus0.mbus_data_wr3_i = wdat_r[3];
    assign bus1.mbus_cmd0_i = cmd1_r[0];
    assign bus1.mbus_cmd1_i = cmd1_r[1];
    assign bus1.mbus_cmd2_i = cmd1_r[2];
    assign bus1.mbus_cmd3_i = cmd1_r[3];
    assign bus1.mbus_addr0_i = addr1_r[0];
    assign bus1.mbus_addr1_i = addr1_r[1];
    assign bus1.mbus_addr2_i = addr1_r[2];
    assign bus1.mbus_addr3_i = addr1_r[3];
    assign bus1.mbus_data_wr0_i = wdat1_r[0];
    assign bus1.mbus_data_wr1_i = wdat1_r[1];
    assign bus1.mbus_data_wr2_i = wdat1_r[2];
    assign bus1.mbus_data_wr3_i = wdat1_r[3];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        ntests++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, a, e);
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v == 4'(1 << i)) r = i;
        return r;
    endfunction

    // Transaction-level model: one access occupies the memory for LAT+2 edges starting at its grant edge.
    int          cyc = 0;
    bit          m_act = 1'b0;
    int          m_cpu = 0;
    int          m_gcyc = 0;
    int          m_prio = 0;
    int          mn;
    logic [31:0] m_mem [16];
    logic [31:0] m_last_rd = '0;
    exp_t        expq[$];
    log_t        alog[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 1'b0;
            m_prio = 0;
            m_last_rd = '0;
            expq.delete();
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
        end else begin
            cyc++;
            if (m_act && cyc == m_gcyc + LAT) begin
                if (cmd_r[m_cpu] == C_WR) m_mem[addr_r[m_cpu][3:0]] = wdat_r[m_cpu];
                else m_last_rd = m_mem[addr_r[m_cpu][3:0]];
            end
            if (m_act && cyc == m_gcyc + LAT + 1) m_prio = (m_cpu + 1) % 4;
            if (m_act && cyc >= m_gcyc + LAT + 2) m_act = 1'b0;
            for (int k = 0; k < 4; k++) begin
                mn = (m_prio + k) % 4;
                if (!m_act && (cmd_r[mn] == C_WR || cmd_r[mn] == C_RD)) begin
                    m_act  = 1'b1;
                    m_cpu  = mn;
                    m_gcyc = cyc;
                    expq.push_back('{mn, cyc + LAT, cmd_r[mn] == C_RD, m_mem[addr_r[mn][3:0]]});
                end
            end
        end
    end

    logic [3:0] mon_eg;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            mon_eg = (m_act && cyc <= m_gcyc + LAT) ? 4'(1 << m_cpu) : 4'b0;
            chk("grant", 32'(bus0.grant_o), 32'(mon_eg));
            chk("busy", 32'(bus0.busy_o), 32'(mon_eg != 4'b0));
            chk("data_rd_hold", bus0.mbus_data_rd_o, m_last_rd);
            if (bus0.mbus_ack_o != 4'b0) begin
                alog.push_back('{idx_of(bus0.mbus_ack_o), cyc});
                if (expq.size() == 0) begin
                    chk("spurious_ack", 32'(bus0.mbus_ack_o), 32'd0);
                end else begin
                    mon_e = expq.pop_front();
                    chk("ack_who", 32'(bus0.mbus_ack_o), 32'(1 << mon_e.cpu));
                    chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                    if (mon_e.rd) chk("rd_data", bus0.mbus_data_rd_o, mon_e.dat);
                end
            end else if (expq.size() != 0 && cyc >= expq[0].cyc) begin
                chk("ack_missing", 32'(bus0.mbus_ack_o), 32'(1 << expq[0].cpu));
                void'(expq.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack", 32'(bus0.mbus_ack_o), 32'd0);
        chk("rst_grant", 32'(bus0.grant_o), 32'd0);
        chk("rst_busy", 32'(bus0.busy_o), 32'd0);
        chk("rst_data_rd", bus0.mbus_data_rd_o, 32'd0);
        chk("rst1_grant", 32'(bus1.grant_o), 32'd0);
        for (int n = 0; n < 4; n++) begin
            cmd_r[n] = C_NOP;
            cmd1_r[n] = C_NOP;
        end
        hold = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int n, input int budget, output int k, output logic [31:0] d);
        k = 0;
        d = '0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            k++;
            if (bus0.mbus_ack_o[n]) begin
                d = bus0.mbus_data_rd_o;
                return;
            end
        end
        ntests++;
        nfail++;
        $display("FAIL wait_ack: cpu%0d got no ack within %0d cycles, want ack", n, budget);
    endtask

    task automatic new_req(input int n);
        int c = $urandom_range(0, 7);
        cmd_r[n]  = 3'(c);
        addr_r[n] = $urandom_range(0, 63);
        wdat_r[n] = $urandom;
        hold[n]   = (c == 1 || c == 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        int na;
        logic [3:0] pend;
        logic [31:0] d;
        for (int n = 0; n < 4; n++) begin
            cmd_r[n] = C_NOP;  addr_r[n] = '0;  wdat_r[n] = '0;
            cmd1_r[n] = C_NOP; addr1_r[n] = '0; wdat1_r[n] = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        do_reset();

        // CPU2 write, then aliased read by CPU0
        cmd_r[2] = C_WR; addr_r[2] = 32'h5; wdat_r[2] = 32'hDEADBEEF;
        @(negedge clk);
        chk("p2_grant", 32'(bus0.grant_o), 32'h4);
        wait_ack(2, 10, k, d);
        chk("p2_ack_latency", 32'(k), 32'(LAT));
        cmd_r[2] = C_NOP;
        cmd_r[0] = C_RD; addr_r[0] = 32'h15;
        wait_ack(0, 12, k, d);
        chk("p2_alias_rd", d, 32'hDEADBEEF);
        cmd_r[0] = C_NOP;
        @(negedge clk);

        // reset during WAIT drops the CPU3 write
        cmd_r[3] = C_WR; addr_r[3] = 32'h7; wdat_r[3] = 32'h12345678;
        @(negedge clk);
        chk("p6_grant", 32'(bus0.grant_o), 32'h8);
        do_reset();
        cmd_r[0] = C_RD; addr_r[0] = 32'h7;
        wait_ack(0, 10, k, d);
        chk("p6_rd_after_reset", d, 32'h0);
        cmd_r[0] = C_NOP;

        // four simultaneous reads from reset
        do_reset();
        base = alog.size();
        for (int n = 0; n < 4; n++) begin
            cmd_r[n] = C_RD;
            addr_r[n] = $urandom_range(0, 63);
        end
        pend = 4'hF;
        for (int t = 0; t < 40 && pend != 4'h0; t++) begin
            @(negedge clk);
            for (int n = 0; n < 4; n++) if (bus0.mbus_ack_o[n]) begin
                cmd_r[n] = C_NOP;
                pend[n] = 1'b0;
            end
        end
        repeat (8) @(negedge clk);
        chk("p3_all_acked", 32'(pend), 32'd0);
        chk("p3_ack_count", 32'(alog.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) if (alog.size() > base + i) begin
            chk("p3_order", 32'(alog[base + i].cpu), 32'(i));
            if (i > 0) chk("p3_spacing", 32'(alog[base + i].cyc - alog[base + i - 1].cyc), 32'(LAT + 2));
        end

        // CPU1 continuous writer versus CPU3 reader
        do_reset();
        base = alog.size();
        cmd_r[1] = C_WR; addr_r[1] = 32'h9; wdat_r[1] = $urandom;
        cmd_r[3] = C_RD; addr_r[3] = 32'h9;
        na = 0;
        for (int t = 0; t < 60 && na < 4; t++) begin
            @(negedge clk);
            if (bus0.mbus_ack_o[1]) begin na++; wdat_r[1] = $urandom; end
            if (bus0.mbus_ack_o[3]) begin na++; addr_r[3] = $urandom_range(0, 63); end
        end
        cmd_r[1] = C_NOP;
        cmd_r[3] = C_NOP;
        repeat (6) @(negedge clk);
        chk("p4_ack_count", 32'(alog.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) if (alog.size() > base + i)
            chk("p4_alternation", 32'(alog[base + i].cpu), (i % 2 == 0) ? 32'd1 : 32'd3);

        // non-memory commands are ignored
        base = alog.size();
        cmd_r[0] = C_RDB; cmd_r[1] = C_NOP; cmd_r[2] = C_WRB; cmd_r[3] = 3'd7;
        repeat (12) @(negedge clk);
        chk("p5_no_ack", 32'(alog.size() - base), 32'd0);
        chk("p5_grant_idle", 32'(bus0.grant_o), 32'd0);
        for (int n = 0; n < 4; n++) cmd_r[n] = C_NOP;

        // random traffic
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            for (int n = 0; n < 4; n++) begin
                if (hold[n]) begin
                    if (bus0.mbus_ack_o[n]) begin
                        if ($urandom_range(0, 1) == 1) new_req(n);
                        else begin cmd_r[n] = C_NOP; hold[n] = 1'b0; end
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    new_req(n);
                end
            end
        end
        for (int n = 0; n < 4; n++) if (!hold[n]) cmd_r[n] = C_NOP;
        for (int t = 0; t < 80 && hold != 4'h0; t++) begin
            @(negedge clk);
            for (int n = 0; n < 4; n++) if (hold[n] && bus0.mbus_ack_o[n]) begin
                hold[n] = 1'b0;
                cmd_r[n] = C_NOP;
            end
        end
        chk("drain_holds", 32'(hold), 32'd0);
        repeat (6) @(negedge clk);
        chk("drain_scoreboard", 32'(expq.size()), 32'd0);

        // MEM_LAT=1 instance
        do_reset();
        cmd1_r[0] = C_WR; addr1_r[0] = 32'h3; wdat1_r[0] = 32'hA5A50001;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus1.mbus_ack_o[0] && k < 10);
        chk("l1_wr_ack_latency", 32'(k), 32'd2);
        cmd1_r[0] = C_NOP;
        @(negedge clk);
        cmd1_r[1] = C_RD; addr1_r[1] = 32'h13;
        @(negedge clk);
        chk("l1_grant", 32'(bus1.grant_o), 32'h2);
        chk("l1_ack_before", 32'(bus1.mbus_ack_o), 32'h0);
        @(negedge clk);
        chk("l1_ack", 32'(bus1.mbus_ack_o), 32'h2);
        chk("l1_rd_data", bus1.mbus_data_rd_o, 32'hA5A50001);
        cmd1_r[1] = C_NOP;
        @(negedge clk);
        chk("l1_ack_cleared", 32'(bus1.mbus_ack_o), 32'h0);
        chk("l1_grant_cleared", 32'(bus1.grant_o), 32'h0);
        chk("l1_rd_hold", bus1.mbus_data_rd_o, 32'hA5A50001);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/mesi_isc_mem_arbiter.md
# mesi_isc_mem_arbiter

Synthesizable main-memory controller shared by the four CPU main buses of the MESI coherence testbench; replaces the behavioural memory/matrix loop. Arbitrates `MESI_ISC_MBUS_CMD_WR` / `MESI_ISC_MBUS_CMD_RD` requests round-robin, sequences a fixed-latency access to an internal word array, and returns a one-cycle memory acknowledge plus read data. Its `mbus_ack_o` is ORed externally with the coherence controller's main-bus acks.

## Interface

- MBUS_CMD_WIDTH, 3, main-bus command width (mesi_isc_pkg encoding)
- ADDR_WIDTH, 32, main-bus address width
- DATA_WIDTH, 32, data width
- DEPTH_LOG2, 4, log2 of memory words (16 words)
- MEM_LAT, 2, cycles from grant to ack; legal range 1..15

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mbus_cmd3_i..mbus_cmd0_i  in  MBUS_CMD_WIDTH each  per-CPU main-bus command
- mbus_addr3_i..mbus_addr0_i  in  ADDR_WIDTH each  per-CPU address
- mbus_data_wr3_i..mbus_data_wr0_i  in  DATA_WIDTH each  per-CPU write data
- mbus_ack_o  out  4  one-hot memory acknowledge, bit n = CPU n
- mbus_data_rd_o  out  DATA_WIDTH  read data, valid while ack of a RD is high
- grant_o  out  4  one-hot currently granted CPU, 0 when idle
- busy_o  out  1  high in WAIT and ACK states

## Operation

- Only CMD_WR and CMD_RD are memory requests; NOP, WR_BROAD, RD_BROAD and undefined codes are ignored.
- Word index = addr[DEPTH_LOG2-1:0]; upper address bits ignored (aliasing wraps).
- Round-robin pointer `prio` (2 bits): search order prio, prio+1, ..., prio+3 mod 4; first requester wins.
- After each ack, `prio` <= granted index + 1 mod 4 (granted CPU becomes lowest priority).
- Requester holds cmd/addr/data stable until it sees its ack; arbiter samples address and write data at the access edge, not at grant.
- FSM:
  - IDLE: if any valid request, latch winner into grant_o, load cnt = MEM_LAT-1, go WAIT; else stay.
  - WAIT: if cnt == 0 perform access (WR: mem[idx] <= data_wr; RD: mbus_data_rd_o <= mem[idx]), set mbus_ack_o = grant_o, go ACK; else cnt <= cnt-1.
  - ACK: next edge clear mbus_ack_o and grant_o, update prio, go IDLE.
- A request from the same CPU is never granted on the cycle its ack is high (ACK always returns through IDLE).
- mbus_data_rd_o holds last read value until next read; unaffected by writes.
- Reset (rst_n low, any time incl. mid-access): state IDLE, mbus_ack_o = 0, grant_o = 0, busy_o = 0, mbus_data_rd_o = 0, prio = 0, cnt = 0, all memory words = 0. Pending access is dropped (no write occurs); requester must re-issue.

## Timing

- Request valid at rising edge E0 in IDLE -> grant_o after E0 -> ack high after edge E0+MEM_LAT for exactly one cycle.
- Total occupancy per transaction MEM_LAT+2 cycles (IDLE sample, MEM_LAT WAIT cycles incl. access, ACK); back-to-back sustained rate one access per MEM_LAT+2 cycles.
- Write becomes visible to a read granted at or after the ACK-state edge.
- At most one bit of mbus_ack_o and grant_o set at any time; busy_o = (state != IDLE).
- Reset assertion clears outputs asynchronously; first grant possible at first rising edge after deassertion.

## Test plan

- Reset then CPU2 WR addr 0x5 data 0xDEADBEEF, MEM_LAT=2 -> grant_o=0100 after E0, mbus_ack_o=0100 one cycle after E2; CPU0 RD addr 0x15 then returns 0xDEADBEEF (alias).
- All four CPUs issue RD simultaneously from reset -> acks in order CPU0,1,2,3, each spaced 4 cycles, no CPU acked twice.
- CPU1 issues WR continuously (re-issues immediately), CPU3 RD pending -> after CPU1 ack, CPU3 granted next; alternation 1,3,1,3.
- CPU0 RD_BROAD, CPU1 NOP, CPU2 WR_BROAD only -> grant_o stays 0000, busy_o 0, no acks.
- rst_n asserted during WAIT of CPU3 WR 0x12345678 to addr 0x7 -> all outputs 0 immediately; subsequent RD addr 0x7 returns 0x00000000.
- MEM_LAT=1: single RD -> ack one cycle after grant; mbus_data_rd_o valid exactly while ack high and holds afterwards.
